// File: rtl/arm_mc_pkg.sv
// arm_mc_pkg: state codes and datapath select encodings shared by the multicycle controller and datapath
package arm_mc_pkg;
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;
  localparam logic [1:0] OP_DP = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR = 2'b10;
  localparam logic [1:0] OP_UNDEF = 2'b11;
  localparam logic [1:0] SRCA_REG = 2'b00;
  localparam logic [1:0] SRCA_PC = 2'b01;
  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: state-to-control table; ports: state/op/mem_ready in, datapath and request controls out
module mc_ctrl_decode
  import arm_mc_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic [STATE_W-1:0] state,
  input  logic [1:0]         op,
  input  logic               mem_ready,
  output logic               ir_write,
  output logic               adr_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         result_src,
  output logic               alu_op,
  output logic               next_pc,
  output logic               branch,
  output logic               reg_w,
  output logic               mem_w,
  output logic               illegal
);
  always_comb begin
    ir_write = 1'b0;
    adr_src = 1'b0;
    alu_src_a = SRCA_REG;
    alu_src_b = SRCB_REG;
    result_src = RES_ALUOUT;
    alu_op = 1'b0;
    next_pc = 1'b0;
    branch = 1'b0;
    reg_w = 1'b0;
    mem_w = 1'b0;
    illegal = 1'b0;
    case (state)
      STATE_W'(FETCH): begin
        alu_src_a = SRCA_PC;
        alu_src_b = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write = mem_ready;
        next_pc = mem_ready;
      end
      STATE_W'(DECODE): begin
        alu_src_a = SRCA_PC;
        alu_src_b = SRCB_FOUR;
        result_src = RES_ALURESULT;
        illegal = (op == OP_UNDEF);
      end
      STATE_W'(MEMADR): alu_src_b = SRCB_IMM;
      STATE_W'(MEMREAD): adr_src = 1'b1;
      STATE_W'(MEMWB): begin
        result_src = RES_DATA;
        reg_w = 1'b1;
      end
      STATE_W'(MEMWRITE): begin
        adr_src = 1'b1;
        mem_w = 1'b1;
      end
      STATE_W'(EXECR): alu_op = 1'b1;
      STATE_W'(EXECI): begin
        alu_src_b = SRCB_IMM;
        alu_op = 1'b1;
      end
      STATE_W'(ALUWB): reg_w = 1'b1;
      STATE_W'(BRANCH): begin
        alu_src_b = SRCB_IMM;
        result_src = RES_ALURESULT;
        branch = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/multicycle_main_fsm.sv
// multicycle_main_fsm: multicycle ARM main controller; ports: clk/Reset/Op/Funct/MemReady in, datapath controls and State out
module multicycle_main_fsm
  import arm_mc_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic [1:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               MemReady,
  output logic               IRWrite,
  output logic               AdrSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic               ALUOp,
  output logic               NextPC,
  output logic               Branch,
  output logic               RegW,
  output logic               MemW,
  output logic               Illegal,
  output logic [STATE_W-1:0] State
);
  logic [STATE_W-1:0] state_q;
  logic unused_funct;
  assign unused_funct = ^Funct[4:1];
  always_ff @(posedge clk) begin
    if (Reset) state_q <= STATE_W'(FETCH);
    else
      case (state_q)
        STATE_W'(FETCH): state_q <= MemReady ? STATE_W'(DECODE) : state_q;
        STATE_W'(DECODE):
          state_q <= (Op == OP_MEM) ? STATE_W'(MEMADR) :
                     (Op == OP_BR)  ? STATE_W'(BRANCH) :
                     (Op == OP_DP)  ? (Funct[5] ? STATE_W'(EXECI) : STATE_W'(EXECR)) :
                                      STATE_W'(FETCH);
        STATE_W'(MEMADR): state_q <= Funct[0] ? STATE_W'(MEMREAD) : STATE_W'(MEMWRITE);
        STATE_W'(MEMREAD): state_q <= MemReady ? STATE_W'(MEMWB) : state_q;
        STATE_W'(MEMWRITE): state_q <= MemReady ? STATE_W'(FETCH) : state_q;
        STATE_W'(EXECR), STATE_W'(EXECI): state_q <= STATE_W'(ALUWB);
        default: state_q <= STATE_W'(FETCH);
      endcase
  end
  // Reset forces the visible state to FETCH immediately so controls never act on a stale state
  assign State = Reset ? STATE_W'(FETCH) : state_q;
  mc_ctrl_decode #(.STATE_W(STATE_W)) u_dec (
    .state     (State),
    .op        (Op),
    .mem_ready (MemReady),
    .ir_write  (IRWrite),
    .adr_src   (AdrSrc),
    .alu_src_a (ALUSrcA),
    .alu_src_b (ALUSrcB),
    .result_src(ResultSrc),
    .alu_op    (ALUOp),
    .next_pc   (NextPC),
    .branch    (Branch),
    .reg_w     (RegW),
    .mem_w     (MemW),
    .illegal   (Illegal)
  );
endmodule

// File: tb/tb_multicycle_main_fsm.sv
// tb_multicycle_main_fsm: directed self-checking bench for the multicycle main controller
module tb_multicycle_main_fsm;
  logic clk = 1'b0;
  logic Reset, MemReady;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic IRWrite, AdrSrc, ALUOp, NextPC, Branch, RegW, MemW, Illegal;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [3:0] State;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  multicycle_main_fsm #(.STATE_W(4)) dut (
    .clk(clk), .Reset(Reset), .Op(Op), .Funct(Funct), .MemReady(MemReady),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ALUOp(ALUOp), .NextPC(NextPC), .Branch(Branch),
    .RegW(RegW), .MemW(MemW), .Illegal(Illegal), .State(State)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    Reset = 1'b1; MemReady = 1'b0; Op = 2'b00; Funct = 6'b0;
    step; step;
    tests++; if (State !== 4'd0) begin fails++; $display("FAIL reset_state got %0d want 0", State); end
    tests++; if ({IRWrite, NextPC, RegW, MemW, Branch, Illegal, AdrSrc, ALUOp} !== 8'b0) begin fails++; $display("FAIL reset_flags got %b want 00000000", {IRWrite, NextPC, RegW, MemW, Branch, Illegal, AdrSrc, ALUOp}); end
    tests++; if ({ALUSrcA, ALUSrcB, ResultSrc} !== 6'b01_10_10) begin fails++; $display("FAIL reset_selects got %b want 011010", {ALUSrcA, ALUSrcB, ResultSrc}); end
    MemReady = 1'b1;
    #1;
    tests++; if ({IRWrite, NextPC} !== 2'b11) begin fails++; $display("FAIL reset_irwrite_follows got %b want 11", {IRWrite, NextPC}); end
    step;
    tests++; if (State !== 4'd0) begin fails++; $display("FAIL reset_hold got %0d want 0", State); end
    Reset = 1'b0;
  endtask
  task automatic test_dp;
    int want[5] = '{0, 1, 6, 8, 0};
    Op = 2'b00; Funct = 6'b000000; MemReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tests++; if (State !== 4'(want[i])) begin fails++; $display("FAIL dp_state[%0d] got %0d want %0d", i, State, want[i]); end
      tests++; if (RegW !== (want[i] == 8)) begin fails++; $display("FAIL dp_regw[%0d] got %b want %b", i, RegW, want[i] == 8); end
      if (want[i] == 6) begin
        tests++; if ({ALUOp, ALUSrcB} !== 3'b1_00) begin fails++; $display("FAIL dp_execr got %b want 100", {ALUOp, ALUSrcB}); end
      end
      if (i < 4) step;
    end
  endtask
  task automatic test_execi;
    int want[5] = '{0, 1, 7, 8, 0};
    Op = 2'b00; Funct = 6'b100000; MemReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tests++; if (State !== 4'(want[i])) begin fails++; $display("FAIL execi_state[%0d] got %0d want %0d", i, State, want[i]); end
      if (want[i] == 7) begin
        tests++; if ({ALUOp, ALUSrcB} !== 3'b1_01) begin fails++; $display("FAIL execi_ctrl got %b want 101", {ALUOp, ALUSrcB}); end
      end
      if (i < 4) step;
    end
  endtask
  task automatic test_load;
    int want[6] = '{0, 1, 2, 3, 4, 0};
    Op = 2'b01; Funct = 6'b011001; MemReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tests++; if (State !== 4'(want[i])) begin fails++; $display("FAIL load_state[%0d] got %0d want %0d", i, State, want[i]); end
      if (want[i] == 2) begin
        tests++; if (ALUSrcB !== 2'b01) begin fails++; $display("FAIL load_memadr_srcb got %b want 01", ALUSrcB); end
      end
      if (want[i] == 3) begin
        tests++; if ({AdrSrc, RegW} !== 2'b10) begin fails++; $display("FAIL load_memread got %b want 10", {AdrSrc, RegW}); end
      end
      if (want[i] == 4) begin
        tests++; if ({ResultSrc, RegW} !== 3'b01_1) begin fails++; $display("FAIL load_memwb got %b want 011", {ResultSrc, RegW}); end
      end
      if (i < 5) step;
    end
  endtask
  task automatic test_store_wait;
    int memw_cycles = 0;
    Op = 2'b01; Funct = 6'b011000; MemReady = 1'b1;
    step; step; step;
    for (int i = 0; i < 4; i++) begin
      MemReady = (i == 3);
      #1;
      tests++; if ({State, MemW, AdrSrc} !== {4'd5, 2'b11}) begin fails++; $display("FAIL store_wait[%0d] got state %0d memw %b adrsrc %b want 5 1 1", i, State, MemW, AdrSrc); end
      memw_cycles += int'(MemW);
      step;
    end
    tests++; if (memw_cycles !== 4) begin fails++; $display("FAIL store_memw_cycles got %0d want 4", memw_cycles); end
    tests++; if ({State, MemW} !== {4'd0, 1'b0}) begin fails++; $display("FAIL store_done got state %0d memw %b want 0 0", State, MemW); end
  endtask
  task automatic test_fetch_wait;
    Op = 2'b10; Funct = 6'b0; MemReady = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      tests++; if ({State, IRWrite, NextPC} !== 6'b0000_00) begin fails++; $display("FAIL fetch_wait[%0d] got state %0d ir %b npc %b want 0 0 0", i, State, IRWrite, NextPC); end
      step;
    end
    MemReady = 1'b1;
    #1;
    tests++; if ({State, IRWrite, NextPC} !== 6'b0000_11) begin fails++; $display("FAIL fetch_ready got state %0d ir %b npc %b want 0 1 1", State, IRWrite, NextPC); end
    step;
    tests++; if (State !== 4'd1) begin fails++; $display("FAIL fetch_to_decode got %0d want 1", State); end
    step;
    tests++; if ({State, Branch, ALUSrcB, ResultSrc} !== {4'd9, 1'b1, 2'b01, 2'b10}) begin fails++; $display("FAIL branch_ctrl got state %0d br %b srcb %b res %b want 9 1 01 10", State, Branch, ALUSrcB, ResultSrc); end
    step;
    tests++; if (State !== 4'd0) begin fails++; $display("FAIL branch_return got %0d want 0", State); end
  endtask
  task automatic test_illegal;
    Op = 2'b11; Funct = 6'b0; MemReady = 1'b1;
    #1;
    tests++; if ({State, Illegal} !== {4'd0, 1'b0}) begin fails++; $display("FAIL illegal_fetch got state %0d ill %b want 0 0", State, Illegal); end
    step;
    tests++; if ({State, Illegal, RegW, MemW} !== {4'd1, 3'b100}) begin fails++; $display("FAIL illegal_decode got state %0d ill %b regw %b memw %b want 1 1 0 0", State, Illegal, RegW, MemW); end
    step;
    tests++; if ({State, Illegal, RegW, MemW} !== {4'd0, 3'b000}) begin fails++; $display("FAIL illegal_return got state %0d ill %b regw %b memw %b want 0 0 0 0", State, Illegal, RegW, MemW); end
  endtask
  task automatic test_reset_mid;
    Op = 2'b01; Funct = 6'b011001; MemReady = 1'b1;
    step; step; step;
    tests++; if (State !== 4'd3) begin fails++; $display("FAIL midreset_memread got %0d want 3", State); end
    MemReady = 1'b0; Reset = 1'b1;
    #1;
    tests++; if ({State, RegW} !== {4'd0, 1'b0}) begin fails++; $display("FAIL midreset_during got state %0d regw %b want 0 0", State, RegW); end
    step;
    Reset = 1'b0;
    #1;
    tests++; if ({State, RegW} !== {4'd0, 1'b0}) begin fails++; $display("FAIL midreset_after got state %0d regw %b want 0 0", State, RegW); end
    step;
    tests++; if ({State, RegW, ResultSrc} !== {4'd0, 1'b0, 2'b10}) begin fails++; $display("FAIL midreset_hold got state %0d regw %b res %b want 0 0 10", State, RegW, ResultSrc); end
  endtask
  initial begin
    test_reset();
    test_dp();
    test_execi();
    test_load();
    test_store_wait();
    test_fetch_wait();
    test_illegal();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/multicycle_main_fsm.md
MULTICYCLE_MAIN_FSM -- requirements
Module: multicycle_main_fsm

Interface
REQ-001 SHALL have parameter STATE_W, default 4: width of the state register and State output.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port Reset  input  1  reset; one clock, reset is synchronous and active-high.
REQ-004 SHALL have port Op  input  2  instruction bits [27:26]: 00 data-processing, 01 memory, 10 branch, 11 undefined.
REQ-005 SHALL have port Funct  input  6  instruction bits [25:20]; Funct[5]=I (immediate), Funct[0]=L/S (load).
REQ-006 SHALL have port MemReady  input  1  memory handshake; the access completes in the cycle it is 1.
REQ-007 SHALL have port IRWrite  output  1  instruction register load enable.
REQ-008 SHALL have port AdrSrc  output  1  memory address select: 0 PC, 1 ALU result register.
REQ-009 SHALL have port ALUSrcA  output  2  ALU A select: 00 register A, 01 PC.
REQ-010 SHALL have port ALUSrcB  output  2  ALU B select: 00 register B, 01 ExtImm, 10 constant 4.
REQ-011 SHALL have port ResultSrc  output  2  result select: 00 ALUOut, 01 Data, 10 ALUResult.
REQ-012 SHALL have port ALUOp  output  1  1 selects ALU decode by Funct; 0 forces ADD.
REQ-013 SHALL have port NextPC, Branch, RegW, MemW  output  1 each  unconditioned requests to the conditional logic.
REQ-014 SHALL have port Illegal  output  1  undefined-opcode indication.
REQ-015 SHALL have port State  output  STATE_W  current state code, for debug.

Function
REQ-016 SHALL implement ten states with codes 0-9: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH.
REQ-017 SHALL transition as follows: FETCH->DECODE only when MemReady=1, otherwise hold.
REQ-018 SHALL transition from DECODE: Op=01->MEMADR; Op=00 & Funct[5]=0->EXECR; Op=00 & Funct[5]=1->EXECI; Op=10->BRANCH; Op=11->FETCH.
REQ-019 SHALL transition from MEMADR: Funct[0]=1->MEMREAD, else ->MEMWRITE.
REQ-020 SHALL transition MEMREAD->MEMWB when MemReady=1, otherwise hold; MEMWB->FETCH.
REQ-021 SHALL transition MEMWRITE->FETCH when MemReady=1, otherwise hold.
REQ-022 SHALL transition EXECR->ALUWB and EXECI->ALUWB; ALUWB->FETCH; BRANCH->FETCH.
REQ-023 SHALL apply these unlisted-output defaults: every output 0, including AdrSrc=0, ALUSrcA=00, ALUSrcB=00 and ResultSrc=00.
REQ-024 SHALL drive FETCH as: ALUSrcA=01, ALUSrcB=10, ResultSrc=10; IRWrite=NextPC=MemReady.
REQ-025 SHALL drive DECODE as: ALUSrcA=01, ALUSrcB=10, ResultSrc=10; Illegal=1 iff Op=11.
REQ-026 SHALL drive MEMADR as ALUSrcB=01.
REQ-027 SHALL drive MEMREAD as AdrSrc=1.
REQ-028 SHALL drive MEMWB as ResultSrc=01, RegW=1.
REQ-029 SHALL drive MEMWRITE as AdrSrc=1, MemW=1 for the whole state.
REQ-030 SHALL drive EXECR as ALUOp=1, and EXECI as ALUSrcB=01, ALUOp=1.
REQ-031 SHALL drive ALUWB as RegW=1.
REQ-032 SHALL drive BRANCH as ALUSrcB=01, ResultSrc=10, Branch=1.
REQ-033 SHALL make outputs pure functions of State, except IRWrite/NextPC (gated by MemReady) and Illegal (depends on Op); there is no input-to-state combinational loop.
REQ-034 SHALL give each instruction class this latency, with MemReady=1 throughout: branch 3 cycles, data-processing 4, store 4, load 5; each MemReady=0 cycle adds one.
REQ-035 SHALL treat an unused state code (10-15) as FETCH on the next edge, with all outputs 0.

Reset
REQ-036 SHALL load State=FETCH on any rising clk with Reset=1, overriding any transition, including mid-instruction and mid-handshake.
REQ-037 SHALL hold these output values while Reset=1: State=0; IRWrite=NextPC=MemReady; all other outputs per FETCH; MemW=RegW=0.

Structure
REQ-038 SHALL take state codes and the ALUSrcA/ALUSrcB/ResultSrc select encodings from a shared package, arm_mc_pkg, used by the datapath too.
REQ-039 SHALL place the combinational state-to-control table in one sub-module, mc_ctrl_decode; the next-state logic and state register stay in the top level.

Verification
REQ-040 SHALL pass this scenario: Reset=1 for 2 cycles, then MemReady=1, Op=00, Funct=000000 -> states 0,1,6,8,0; RegW=1 only in state 8.
REQ-041 SHALL pass this scenario: load, Op=01, Funct=011001, MemReady=1 -> 0,1,2,3,4,0; ResultSrc=01 and RegW=1 in state 4.
REQ-042 SHALL pass this scenario: store, Op=01, Funct=011000, MemReady=0 for 3 cycles in MEMWRITE -> MemW=1 for 4 cycles, then FETCH.
REQ-043 SHALL pass this scenario: FETCH with MemReady=0 for 2 cycles -> IRWrite=NextPC=0 and State=0; on the third cycle IRWrite=1, then DECODE.
REQ-044 SHALL pass this scenario: Op=11 -> Illegal=1 in DECODE for 1 cycle, next state FETCH, no RegW/MemW pulse.
REQ-045 SHALL pass this scenario: Reset=1 asserted in MEMREAD -> State=0 on the next edge; no MEMWB and no RegW pulse.
